prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Program memory that fills and serves the simple_cpu instruction store.
//  Write side: a byte stream (valid/ready) carries 16-bit instruction words, high byte first.
//  Read side: responds to the CPU's fetch requests with one-cycle latency.
//  cpu_run gates the CPU reset so the CPU never fetches a half-written program.
// PARAMETERS
//  DEPTH   32  instruction words stored (power of two)
//  ADDR_W  5   log2(DEPTH)
//  DATA_W  16  instruction width: opcode[15:12], operand[11:0]
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  load_start  in   1       pulse: begin a new load at address 0
//  load_stop   in   1       pulse: end the load early and NOP-fill the rest
//  byte_valid  in   1       byte_data is valid
//  byte_data   in   8       program byte, high byte of each word first
//  byte_ready  out  1       loader accepts a byte this cycle
//  fetch_req   in   1       CPU fetch request
//  fetch_addr  in   6       CPU program counter
//  fetch_valid out  1       fetch_data is valid (one cycle after fetch_req)
//  fetch_data  out  16      instruction word
//  cpu_run     out  1       1 = program stable; drive into the CPU reset_n
//  load_done   out  1       one-cycle pulse when a load (full or stopped) completes
//  err_ovf     out  1       sticky: byte_valid seen while not loading
// BEHAVIOUR
//  Reset values:
//   - State RUN; cpu_run=1; all other outputs 0; wr_ptr=0; hi_byte=0.
//   - Memory contents are not touched by reset. They are initialised to 0x0000 (NOP) at configuration.
//  FSM states: RUN, LOAD_HI, LOAD_LO, FILL, DONE.
//   - RUN: load_start -> LOAD_HI; wr_ptr=0; cpu_run=0; err_ovf cleared.
//   - LOAD_HI: on a byte handshake, hi_byte<=byte_data and go to LOAD_LO.
//   - LOAD_LO: on a byte handshake, write mem[wr_ptr]={hi_byte,byte_data} and wr_ptr++.
//     If wr_ptr was DEPTH-1, go to DONE; otherwise go to LOAD_HI.
//   - load_stop in LOAD_HI or LOAD_LO -> FILL. A held high byte is discarded.
//     A byte handshaked in the same cycle is dropped.
//   - FILL: write 0x0000 to mem[wr_ptr] and wr_ptr++, one word per cycle.
//     After writing DEPTH-1, go to DONE. If load_stop arrives with wr_ptr==0, every word is filled.
//   - DONE: load_done=1 for exactly one cycle, cpu_run<=1, -> RUN.
//  Priority:
//   - load_start in any state restarts at LOAD_HI with wr_ptr=0 and cpu_run=0.
//   - load_start beats load_stop.
//   - load_start beats an in-flight byte, which is dropped.
//  Handshake:
//   - byte_ready=1 only in LOAD_HI and LOAD_LO. It is decoded from the registered state, so it has no combinational path from inputs.
//   - A transfer happens only when byte_valid & byte_ready.
//   - Bytes may arrive back to back: one byte per cycle, one word every 2 cycles.
//  err_ovf: set when byte_valid=1 in RUN, FILL or DONE. Held until load_start or reset.
//  Fetch path:
//   - fetch_req is registered.
//   - On the next cycle fetch_valid=1 and fetch_data=mem[fetch_addr[4:0]].
//   - If fetch_addr>=DEPTH, fetch_data=0x0000 (NOP). Addresses never wrap.
//   - Fetches are served in every state. While cpu_run=0 they return 0x0000.
//   - A read and a write to the same address in the same cycle return the old word (read-first).
//   - Without fetch_req, fetch_valid=0 and fetch_data holds its last value.
//  Reset mid-load: the FSM returns to RUN with cpu_run=1. Words already written stay; the rest keep prior contents.
// TESTING
//  T1: reset, fetch addr 0..31 -> fetch_valid one cycle after each req, data 0x0000, cpu_run=1.
//  T2: load_start, 64 bytes {0x10,0x0F,0x20,0x02,0x30,0x00,...} back to back ->
//      byte_ready high for 64 cycles, load_done pulses once, cpu_run rises.
//      Then fetch 0,1,2 -> 0x100F, 0x2002, 0x3000.
//  T3: load 3 words then load_stop -> FILL takes 29 cycles; fetch 3..31 -> 0x0000; fetch 0..2 -> loaded values.
//  T4: load_stop after the high byte 0x40 of word 2 -> 0x40 is discarded and mem[2]=0x0000.
//      Same-cycle load_start+load_stop -> load restarts at address 0.
//  T5: byte_valid=1 in RUN -> err_ovf=1 and stays set; the next load_start clears it.
//      fetch_addr=40 -> data 0x0000.
//  T6: assert reset_n=0 after 5 loaded words -> cpu_run=1 and all outputs at reset values.
//      mem[0..4] retain the new words.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Instruction store for simple_cpu: fills from a byte stream (high byte first) and serves
// one-cycle-latency fetches. cpu_run holds the CPU in reset while a program is being written.
module prog_mem_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              load_stop,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              fetch_req,
   input  logic [ADDR_W:0]   fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              cpu_run,
   output logic              load_done,
   output logic              err_ovf
);

   typedef enum logic [2:0] {RUN, LOAD_HI, LOAD_LO, FILL, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [7:0]        hi_byte;
   logic              byte_hs;
   logic              last_word;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;

   // Contents come up as NOPs at configuration and are never cleared by reset.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   assign byte_ready = (state == LOAD_HI) || (state == LOAD_LO);
   assign byte_hs    = byte_valid && byte_ready;
   assign last_word  = (wr_ptr == ADDR_W'(DEPTH - 1));

   // load_start and load_stop both suppress the low-byte write; FILL yields only to load_start.
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (!load_start) begin
         if (state == LOAD_LO && byte_hs && !load_stop) begin
            mem_we    = 1'b1;
            mem_wdata = {hi_byte, byte_data};
         end else if (state == FILL) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         wr_ptr    <= '0;
         hi_byte   <= '0;
         cpu_run   <= 1'b1;
         load_done <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         load_done <= 1'b0;
         if (load_start) begin
            state   <= LOAD_HI;
            wr_ptr  <= '0;
            hi_byte <= '0;
            cpu_run <= 1'b0;
            err_ovf <= 1'b0;
         end else begin
            if (byte_valid && (state == RUN || state == FILL || state == DONE))
               err_ovf <= 1'b1;
            case (state)
               RUN: ;
               LOAD_HI: begin
                  if (load_stop) begin
                     state <= FILL;
                  end else if (byte_hs) begin
                     hi_byte <= byte_data;
                     state   <= LOAD_LO;
                  end
               end
               LOAD_LO: begin
                  if (load_stop) begin
                     state <= FILL;
                  end else if (byte_hs) begin
                     wr_ptr <= wr_ptr + 1'b1;
                     state  <= last_word ? DONE : LOAD_HI;
                  end
               end
               FILL: begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (last_word) state <= DONE;
               end
               DONE: begin
                  load_done <= 1'b1;
                  cpu_run   <= 1'b1;
                  state     <= RUN;
               end
               default: state <= RUN;
            endcase
         end
      end
   end

   // Read-first: a same-cycle write to the fetched word is not visible until the next fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_valid <= 1'b0;
         fetch_data  <= '0;
      end else begin
         fetch_valid <= fetch_req;
         if (fetch_req)
            fetch_data <= (fetch_addr[ADDR_W] || !cpu_run) ? '0 : mem[fetch_addr[ADDR_W-1:0]];
      end
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: load, early stop / NOP fill, priorities, overflow flag,
// out-of-range fetch and reset during a load.
module tb_prog_mem_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_start, load_stop, byte_valid, fetch_req;
   logic [7:0]  byte_data;
   logic [5:0]  fetch_addr;
   logic        byte_ready, fetch_valid, cpu_run, load_done, err_ovf;
   logic [15:0] fetch_data;

   int n_chk  = 0;
   int n_pass = 0;

   prog_mem_loader dut (
      .clk(clk), .reset_n(reset_n),
      .load_start(load_start), .load_stop(load_stop),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .cpu_run(cpu_run), .load_done(load_done), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int a, input logic [15:0] exp);
      fetch_req  = 1'b1;
      fetch_addr = 6'(a);
      tick();
      fetch_req = 1'b0;
      check($sformatf("fetch_valid[%0d]", a), 16'(fetch_valid), 16'h1);
      check($sformatf("fetch_data[%0d]", a), fetch_data, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic pulse_stop();
      load_stop = 1'b1;
      tick();
      load_stop = 1'b0;
   endtask

   // Bounded wait for the load_done pulse; returns cycles taken.
   task automatic wait_done(input string tag, output int cycles);
      cycles = 0;
      while (!load_done && cycles < 100) begin
         tick();
         cycles++;
      end
      check(tag, 16'(load_done), 16'h1);
   endtask

   function automatic logic [15:0] word_of(input int i);
      case (i)
         0:       return 16'h100F;
         1:       return 16'h2002;
         2:       return 16'h3000;
         default: return {4'(i), 12'(i * 3)};
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, ".cpu_run"},     16'(cpu_run),     16'h1);
      check({tag, ".byte_ready"},  16'(byte_ready),  16'h0);
      check({tag, ".load_done"},   16'(load_done),   16'h0);
      check({tag, ".err_ovf"},     16'(err_ovf),     16'h0);
      check({tag, ".fetch_valid"}, 16'(fetch_valid), 16'h0);
      check({tag, ".fetch_data"},  fetch_data,       16'h0);
   endtask

   initial begin
      int ready_cnt;
      int cyc;
      logic [15:0] w;

      reset_n = 1'b0;
      load_start = 1'b0; load_stop = 1'b0; byte_valid = 1'b0; byte_data = '0;
      fetch_req = 1'b0; fetch_addr = '0;

      // T1: reset values, then every word reads back as NOP
      repeat (2) tick();
      check_reset_outputs("t1_reset");
      reset_n = 1'b1;
      tick();
      for (int a = 0; a < 32; a++) fetch(a, 16'h0000);
      tick();
      check("t1_valid_drop", 16'(fetch_valid), 16'h0);
      check("t1_cpu_run", 16'(cpu_run), 16'h1);

      // T2: full 64-byte back-to-back load
      pulse_start();
      check("t2_cpu_run_low", 16'(cpu_run), 16'h0);
      ready_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         w = word_of(k / 2);
         if (byte_ready) ready_cnt++;
         send_byte((k % 2 == 0) ? w[15:8] : w[7:0]);
      end
      check("t2_ready_cycles", 16'(ready_cnt), 16'd64);
      check("t2_ready_after", 16'(byte_ready), 16'h0);
      check("t2_done_early", 16'(load_done), 16'h0);
      tick();
      check("t2_done_pulse", 16'(load_done), 16'h1);
      check("t2_cpu_run_up", 16'(cpu_run), 16'h1);
      tick();
      check("t2_done_clear", 16'(load_done), 16'h0);
      check("t2_err_ovf", 16'(err_ovf), 16'h0);
      fetch(0, 16'h100F);
      fetch(1, 16'h2002);
      fetch(2, 16'h3000);
      fetch(31, word_of(31));

      // T3: three words then load_stop; 29 fill cycles plus DONE before the pulse
      pulse_start();
      fetch(0, 16'h0000);
      send_word(16'hA001);
      send_word(16'hB002);
      send_word(16'hC003);
      pulse_stop();
      wait_done("t3_done", cyc);
      check("t3_fill_cycles", 16'(cyc), 16'd30);
      tick();
      for (int a = 3; a < 32; a++) fetch(a, 16'h0000);
      fetch(0, 16'hA001);
      fetch(1, 16'hB002);
      fetch(2, 16'hC003);

      // T4: stop after a held high byte, with a byte in flight that must be dropped
      pulse_start();
      send_word(16'h1111);
      send_word(16'h2222);
      send_byte(8'h40);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      pulse_stop();
      byte_valid = 1'b0;
      wait_done("t4_done", cyc);
      tick();
      fetch(2, 16'h0000);
      fetch(0, 16'h1111);
      fetch(1, 16'h2222);
      check("t4_err_ovf", 16'(err_ovf), 16'h0);

      // T4b: simultaneous start+stop restarts at address 0
      pulse_start();
      send_byte(8'h12);
      load_start = 1'b1;
      load_stop  = 1'b1;
      tick();
      load_start = 1'b0;
      load_stop  = 1'b0;
      check("t4b_ready", 16'(byte_ready), 16'h1);
      check("t4b_cpu_run", 16'(cpu_run), 16'h0);
      send_word(16'h5678);
      pulse_stop();
      wait_done("t4b_done", cyc);
      tick();
      fetch(0, 16'h5678);
      fetch(1, 16'h0000);

      // T5: stray byte in RUN sets the sticky flag; out-of-range fetches are NOPs
      send_byte(8'hEE);
      check("t5_err_set", 16'(err_ovf), 16'h1);
      tick();
      tick();
      check("t5_err_held", 16'(err_ovf), 16'h1);
      fetch(32, 16'h0000);
      fetch(40, 16'h0000);
      pulse_start();
      check("t5_err_clear", 16'(err_ovf), 16'h0);

      // T6: reset after five words of a new load
      for (int i = 0; i < 5; i++) send_word(16'h0A01 + 16'(i));
      fetch_req = 1'b1;
      fetch_addr = 6'd0;
      tick();
      fetch_req = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("t6_reset");
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) fetch(i, 16'h0A01 + 16'(i));
      fetch(5, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
